// File: rtl/ebi_pkg.sv
// Shared types for the EBI bus initiator.
// State enum, request bundle and bank codes.
package ebi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ALE,
    ST_DSETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP
  } ebi_state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  bank;
    logic [15:0] addr;
    logic [15:0] wdata;
  } ebi_req_t;

  localparam logic [2:0] EBI_BANK_OAM         = 3'd0;
  localparam logic [2:0] EBI_BANK_VRAM_SPRITE = 3'd1;
  localparam logic [2:0] EBI_BANK_PALETTE     = 3'd3;

  localparam int EBI_FIFO_DEPTH = 4;

  function automatic logic [7:0] cyc_load(
    input int unsigned n
  );
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/ebi_req_fifo.sv
// Request queue in front of the EBI sequencer.
// Synchronous reset empties the queue.
module ebi_req_fifo
  import ebi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  ebi_req_t      din,
  input  logic          pop,
  output ebi_req_t      dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  ebi_req_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count
             + (AW+1)'(do_push)
             - (AW+1)'(do_pop);
    end
  end

  // Storage, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ebi_master.sv
// Multiplexed EBI address/data bus initiator.
// Define EBI_MASTER_FIFO_EN for a 4-deep request queue.
module ebi_master
  import ebi_pkg::*;
#(
  parameter int unsigned ADDR_SETUP_CYC = 2,
  parameter int unsigned ALE_CYC        = 2,
  parameter int unsigned DATA_SETUP_CYC = 2,
  parameter int unsigned STROBE_CYC     = 4,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned IDLE_CYC       = 8
) (
  input  logic        clk_100m,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_bank,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [15:0] ebi_ad_o,
  output logic        ebi_ad_oe,
  input  logic [15:0] ebi_ad_i,
  output logic        ebi_ale,
  output logic        ebi_we,
  output logic        ebi_re,
  output logic [2:0]  bank_select,
  output logic        busy
);

  ebi_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  ebi_req_t    cur_q, cur_d;
  ebi_req_t    new_req;
  logic        have_req;
  logic        start;
  logic        sample_rd;
  logic [15:0] ad_d;
  logic        oe_d;
  logic        ale_d;
  logic        we_d;
  logic        re_d;

`ifdef EBI_MASTER_FIFO_EN
  localparam int FAW = $clog2(EBI_FIFO_DEPTH);

  ebi_req_t     in_req;
  logic         push;
  logic         fifo_empty;
  logic         fifo_full;
  logic [FAW:0] fifo_count;
  logic [FAW+1:0] fifo_next;

  assign in_req = '{
    write: req_write,
    bank:  req_bank,
    addr:  req_addr,
    wdata: req_wdata
  };
  assign push     = req_valid && req_ready && !fifo_full;
  assign have_req = !fifo_empty;
  assign fifo_next = {1'b0, fifo_count}
                   + (FAW+2)'(push)
                   - (FAW+2)'(start);

  ebi_req_fifo #(
    .DEPTH (EBI_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_100m),
    .reset (reset),
    .push  (push),
    .din   (in_req),
    .pop   (start),
    .dout  (new_req),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );
`else
  assign new_req = '{
    write: req_write,
    bank:  req_bank,
    addr:  req_addr,
    wdata: req_wdata
  };
  assign have_req = req_valid && req_ready;
`endif

  // Phase sequencing: each phase runs its cycle count down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (have_req) begin
        start   = 1'b1;
        state_d = ST_ADDR;
        cnt_d   = cyc_load(ADDR_SETUP_CYC);
      end
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          state_d = ST_ALE;
          cnt_d   = cyc_load(ALE_CYC);
        end
        ST_ALE: begin
          state_d = ST_DSETUP;
          cnt_d   = cyc_load(DATA_SETUP_CYC);
        end
        ST_DSETUP: begin
          state_d = ST_STROBE;
          cnt_d   = cyc_load(STROBE_CYC);
        end
        ST_STROBE: begin
          state_d = ST_HOLD;
          cnt_d   = cyc_load(HOLD_CYC);
        end
        ST_HOLD: begin
          state_d = ST_GAP;
          cnt_d   = cyc_load(IDLE_CYC);
        end
        ST_GAP: begin
          state_d = ST_IDLE;
`ifdef EBI_MASTER_FIFO_EN
          // Chain straight into the next queued request.
          if (have_req) begin
            start   = 1'b1;
            state_d = ST_ADDR;
            cnt_d   = cyc_load(ADDR_SETUP_CYC);
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign cur_d     = start ? new_req : cur_q;
  assign sample_rd = (state_q == ST_STROBE)
                  && (cnt_q == 8'd0)
                  && !cur_q.write;

  // Bus drive values for the phase entered next cycle.
  always_comb begin
    ad_d  = '0;
    oe_d  = 1'b0;
    ale_d = 1'b1;
    we_d  = 1'b1;
    re_d  = 1'b1;
    unique case (state_d)
      ST_ADDR: begin
        ad_d = cur_d.addr;
        oe_d = 1'b1;
      end
      ST_ALE: begin
        ad_d  = cur_d.addr;
        oe_d  = 1'b1;
        ale_d = 1'b0;
      end
      ST_DSETUP, ST_HOLD: begin
        if (cur_d.write) begin
          ad_d = cur_d.wdata;
          oe_d = 1'b1;
        end
      end
      ST_STROBE: begin
        if (cur_d.write) begin
          ad_d = cur_d.wdata;
          oe_d = 1'b1;
          we_d = 1'b0;
        end else begin
          re_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State, latched request and registered bus/handshake outputs.
  always_ff @(posedge clk_100m) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      ebi_ad_o    <= '0;
      ebi_ad_oe   <= 1'b0;
      ebi_ale     <= 1'b1;
      ebi_we      <= 1'b1;
      ebi_re      <= 1'b1;
      bank_select <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      ebi_ad_o  <= ad_d;
      ebi_ad_oe <= oe_d;
      ebi_ale   <= ale_d;
      ebi_we    <= we_d;
      ebi_re    <= re_d;
      rsp_valid <= sample_rd;
      if (sample_rd)
        rsp_rdata <= ebi_ad_i;
      if (start)
        bank_select <= new_req.bank;
`ifdef EBI_MASTER_FIFO_EN
      req_ready <= fifo_next < (FAW+2)'(EBI_FIFO_DEPTH);
      busy      <= (state_d != ST_IDLE) || (fifo_next != '0);
`else
      req_ready <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
`endif
    end
  end

endmodule

// File: tb/tb_ebi_master.sv
// Scoreboard bench for ebi_master with a simple EBI slave model.
// Bus phases are checked per cycle against each request's start time.
module tb_ebi_master;
  import ebi_pkg::*;

  logic        clk_100m = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_bank;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] ebi_ad_o;
  logic        ebi_ad_oe;
  logic [15:0] ebi_ad_i = '0;
  logic        ebi_ale;
  logic        ebi_we;
  logic        ebi_re;
  logic [2:0]  bank_select;
  logic        busy;

  ebi_master dut (
    .clk_100m    (clk_100m),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_bank    (req_bank),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .ebi_ad_o    (ebi_ad_o),
    .ebi_ad_oe   (ebi_ad_oe),
    .ebi_ad_i    (ebi_ad_i),
    .ebi_ale     (ebi_ale),
    .ebi_we      (ebi_we),
    .ebi_re      (ebi_re),
    .bank_select (bank_select),
    .busy        (busy)
  );

  always #5 clk_100m = ~clk_100m;

`ifdef EBI_MASTER_FIFO_EN
  localparam int FIFO_LAT = 1;
`else
  localparam int FIFO_LAT = 0;
`endif

  typedef struct {
    bit          w;
    logic [2:0]  b;
    logic [15:0] a;
    logic [15:0] d;
    int          start;
  } bus_t;

  typedef struct {
    logic [15:0] d;
    int          start;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int ncyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int last_start = -1000;

  always @(posedge clk_100m) ncyc <= ncyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, ncyc);
    end
  endtask

  // Slave model standing in for display_driver.
  logic [15:0] mem [logic [18:0]];
  logic [18:0] key = '0;
  bit          preloaded = 0;
  always @(negedge clk_100m) begin
    if (!preloaded) begin
      mem[{3'd3, 16'h000B}] = 16'h00C8;
      preloaded = 1;
    end
    if (!ebi_ale) key = {bank_select, ebi_ad_o};
    if (!ebi_we) mem[key] = ebi_ad_o;
    ebi_ad_i = (!ebi_re && mem.exists(key)) ? mem[key] : 16'h0000;
  end

  // Bus phase monitor.
  bus_t        bt;
  int          rel;
  logic        e_oe;
  logic [15:0] e_ad;
  logic [15:0] msk;
  always @(negedge clk_100m) begin
    if (ncyc >= 2 && !reset) begin
      check("strobe_excl",
            {62'd0, !ebi_we && !ebi_re,
             !ebi_ale && (!ebi_we || !ebi_re)}, 64'd0);
      if (bus_q.size() > 0 && ncyc - bus_q[0].start + 1 >= 1) begin
        bt  = bus_q[0];
        rel = ncyc - bt.start + 1;
        e_oe = (rel <= 4) ? 1'b1 : (rel <= 12) ? bt.w : 1'b0;
        e_ad = (rel <= 4) ? bt.a : (rel <= 12 && bt.w) ? bt.d : 16'h0;
        msk  = (!bt.w && rel >= 5 && rel <= 12) ? 16'h0 : 16'hFFFF;
        check($sformatf("bus_rel%0d", rel),
              {42'd0, ebi_ad_oe, ebi_ad_o & msk, ebi_ale,
               ebi_we, ebi_re, bank_select},
              {42'd0, e_oe, e_ad & msk, !(rel == 3 || rel == 4),
               !(bt.w && rel >= 7 && rel <= 10),
               !(!bt.w && rel >= 7 && rel <= 10), bt.b});
        if (rel >= 20) void'(bus_q.pop_front());
      end else begin
        check("bus_idle",
              {44'd0, ebi_ad_oe, ebi_ad_o, ebi_ale, ebi_we, ebi_re},
              {44'd0, 1'b0, 16'h0, 3'b111});
      end
    end
  end

  // Read response monitor.
  rsp_t rr;
  always @(negedge clk_100m) begin
    if (ncyc >= 2 && !reset) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
        end else begin
          rr = rsp_q.pop_front();
          check("rsp_data_lat",
                {40'd0, rsp_rdata, 8'(ncyc - rr.start + 1)},
                {40'd0, rr.d, 8'd11});
        end
      end else if (rsp_q.size() > 0 &&
                   ncyc - rsp_q[0].start + 1 > 11) begin
        rr = rsp_q.pop_front();
        check("rsp_missing", {63'd0, rsp_valid}, 64'd1);
      end
    end
  end

  task automatic issue(input bit w, input logic [2:0] b,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, output int waited);
    int n0;
    int st;
    waited    = 0;
    req_valid = 1'b1;
    req_write = w;
    req_bank  = b;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && waited < 300) begin
      @(posedge clk_100m);
      #2;
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk_100m);
    #2;
    n0 = ncyc;
    req_valid = 1'b0;
    st = (n0 + FIFO_LAT > last_start + 20) ? n0 + FIFO_LAT
                                           : last_start + 20;
    last_start = st;
    bus_q.push_back('{w, b, a, d, st});
    if (!w) rsp_q.push_back('{exp_rd, st});
  endtask

  logic [15:0] pal [12] = '{
    16'hFFFF, 16'h00FF, 16'hF0F0, 16'h0F0F,
    16'h1234, 16'hABCD, 16'h8000, 16'h0001,
    16'h5A5A, 16'hA5A5, 16'hC008, 16'h00C8
  };

  initial begin
    int wt;
    int pulses;
    int g;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_bank  = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk_100m);
    #3;
    check("rst_bus", {44'd0, ebi_ad_oe, ebi_ad_o, ebi_ale, ebi_we, ebi_re},
          {44'd0, 1'b0, 16'h0, 3'b111});
    check("rst_bank", {61'd0, bank_select}, 64'd0);
    check("rst_rsp", {47'd0, rsp_valid, rsp_rdata}, 64'd0);
    check("rst_hs", {62'd0, req_ready, busy}, 64'd2);
    @(posedge clk_100m);
    #2;
    reset = 1'b0;

    // Single write then single read.
    issue(1'b1, EBI_BANK_OAM, 16'h0001, 16'hC008, 16'h0, wt);
    #1;
    check("busy_active", {63'd0, busy}, 64'd1);
    issue(1'b0, EBI_BANK_PALETTE, 16'h000B, 16'h0, 16'h00C8, wt);

    // Palette loopback.
    for (int i = 0; i < 12; i++)
      issue(1'b1, EBI_BANK_PALETTE, 16'h0010 + 16'(i), pal[i], 16'h0, wt);
    for (int i = 0; i < 12; i++)
      issue(1'b0, EBI_BANK_PALETTE, 16'h0010 + 16'(i), 16'h0, pal[i], wt);
    while (bus_q.size() > 0) @(posedge clk_100m);
    #2;

    // Reset in the middle of a write strobe.
    issue(1'b1, EBI_BANK_VRAM_SPRITE, 16'h0042, 16'h7777, 16'h0, wt);
    repeat (7) @(posedge clk_100m);
    #2;
    reset = 1'b1;
    bus_q.delete();
    rsp_q.delete();
    last_start = -1000;
    @(posedge clk_100m);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_we_oe", {62'd0, ebi_we, ebi_ad_oe}, 64'd2);
    check("midrst_hs", {62'd0, req_ready, busy}, 64'd2);
    pulses = 0;
    repeat (15) begin
      @(negedge clk_100m);
      if (rsp_valid) pulses++;
    end
    check("midrst_no_rsp", 64'(pulses), 64'd0);
    @(posedge clk_100m);
    #2;

`ifdef EBI_MASTER_FIFO_EN
    // Fill the queue; the last push must stall.
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, EBI_BANK_OAM, 16'h0100 + 16'(i),
            16'h1000 + 16'(i), 16'h0, wt);
      if (i == 5) check("fifo_stall", {63'd0, wt > 0}, 64'd1);
    end
`endif

    // Read after the reset recovery.
    issue(1'b0, EBI_BANK_PALETTE, 16'h0013, 16'h0, pal[3], wt);

    g = 0;
    while ((bus_q.size() + rsp_q.size()) > 0 && g < 500) begin
      @(posedge clk_100m);
      g++;
    end
    #2;
    check("drain", 64'(bus_q.size() + rsp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
